tx_out_framer: RTL

Per-port egress framer sitting directly downstream of `tx_manage_fsm` instance `NUB`. It takes the reassembled `{valid, nub, data}` word stream and delimits frames using the control word, which is decoded with the existing `ctrl_verify` module. Words are buffered in a local FIFO, and frames are presented to the port transmitter on a valid/ready interface with sop/eop. Back-pressure toward the chain is applied through `keep_out`, which drives `tx_manage_fsm.keep_in`.

---
 rtl/tx_out_framer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/tx_out_framer.sv
// Egress framer: delimits frames from the reassembled word stream, buffers them
// in a word FIFO and presents them to the port transmitter with sop/eop.

// Control word decoder. A control word carries tag 4'hC in its top nibble and
// zero reserved bits; its frame length sits in the low WIDTH_LENGTH bits.
module ctrl_verify #(
  parameter int WIDTH_DATA   = 32,
  parameter int WIDTH_LENGTH = 6
) (
  input  logic [WIDTH_DATA-1:0]   data_in,
  output logic                    verify_en,
  output logic [WIDTH_LENGTH-1:0] length
);

  assign verify_en = (data_in[WIDTH_DATA-1 -: 4] == 4'hC) &&
                     (data_in[WIDTH_DATA-5:WIDTH_LENGTH] == '0);
  assign length    = data_in[WIDTH_LENGTH-1:0];

endmodule

module tx_out_framer #(
  parameter int NUB             = 0,
  parameter int FIFO_DEPTH      = 32,
  parameter int AF_GAP          = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int PORT_NUB_TOTAL  = 4,
  parameter int DATA_LENGTH_MAX = 64,
  localparam int WIDTH_DATA     = DATA_WIDTH,
  localparam int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL),
  localparam int WIDTH_PORT     = WIDTH_SEL + WIDTH_DATA,
  localparam int WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_PORT-1:0] data_in,
  input  logic [WIDTH_SEL-1:0]  nub_in,
  input  logic                  valid_in,
  output logic                  keep_out,
  output logic [WIDTH_DATA-1:0] tx_data,
  output logic [WIDTH_SEL-1:0]  tx_src,
  output logic                  tx_valid,
  output logic                  tx_sop,
  output logic                  tx_eop,
  input  logic                  tx_ready,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 + WIDTH_SEL + WIDTH_DATA;
  localparam logic [WIDTH_SEL-1:0] NUB_SEL    = WIDTH_SEL'(NUB);
  localparam logic [CW-1:0]        KEEP_LEVEL = CW'(FIFO_DEPTH - AF_GAP);

  typedef enum logic {IDLE, BODY} state_t;

  state_t                  state;
  logic [WIDTH_LENGTH-1:0] remain;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic [CW-1:0] count, count_next, visible;

  logic [WIDTH_DATA-1:0]   payload;
  logic [WIDTH_SEL-1:0]    dest;
  logic                    verify_en;
  logic [WIDTH_LENGTH-1:0] length;
  logic                    consume, for_port, push, pop, drop;
  logic                    entry_sop, entry_eop;
  logic [EW-1:0]           entry, head;

  assign payload = data_in[WIDTH_DATA-1:0];
  assign dest    = data_in[WIDTH_PORT-1 -: WIDTH_SEL];

  ctrl_verify #(
    .WIDTH_DATA  (WIDTH_DATA),
    .WIDTH_LENGTH(WIDTH_LENGTH)
  ) u_ctrl_verify (
    .data_in  (payload),
    .verify_en(verify_en),
    .length   (length)
  );

  // Classify the consumed word: in BODY every word for this port is payload,
  // in IDLE only a verified control word opens a frame.
  always_comb begin
    consume   = valid_in && !keep_out;
    for_port  = (dest == NUB_SEL);
    push      = 1'b0;
    drop      = 1'b0;
    entry_sop = 1'b0;
    entry_eop = 1'b0;
    if (consume) begin
      if (!for_port) begin
        drop = 1'b1;
      end else if (state == BODY) begin
        push      = 1'b1;
        entry_eop = (remain == WIDTH_LENGTH'(1));
      end else if (verify_en) begin
        push      = 1'b1;
        entry_sop = 1'b1;
        entry_eop = (length == '0);
      end else begin
        drop = 1'b1;
      end
    end
  end

  // The output register is refilled from entries already in memory, so a word
  // written this edge becomes visible one edge later.
  always_comb begin
    pop         = tx_valid && tx_ready;
    entry       = {entry_sop, entry_eop, nub_in, payload};
    count_next  = count + CW'(push) - CW'(pop);
    visible     = count - CW'(pop);
    rd_ptr_next = rd_ptr + AW'(pop);
    head        = mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remain    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      keep_out  <= 1'b0;
      tx_valid  <= 1'b0;
      tx_sop    <= 1'b0;
      tx_eop    <= 1'b0;
      tx_src    <= '0;
      tx_data   <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      keep_out <= (count_next >= KEEP_LEVEL);

      if (visible != '0) begin
        {tx_sop, tx_eop, tx_src, tx_data} <= head;
        tx_valid <= 1'b1;
      end else begin
        {tx_sop, tx_eop, tx_src, tx_data} <= '0;
        tx_valid <= 1'b0;
      end

      if (push) begin
        case (state)
          IDLE: begin
            remain <= length;
            if (length != '0) begin
              state <= BODY;
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
          BODY: begin
            remain <= remain - WIDTH_LENGTH'(1);
            if (remain == WIDTH_LENGTH'(1)) begin
              frame_cnt <= frame_cnt + 16'd1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (drop && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule
